// File: rtl/axi_read_arbiter.sv
// Shares one AXI read channel between instruction fetch and data read.
// At most one outstanding read per requester; R beats are routed back by RID.
module axi_read_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        inst_rready,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [2:0]  data_size,
  output logic        data_addr_ok,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  input  logic        data_rready,
  output logic        inst_busy,
  output logic        data_busy,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic [7:0]  arlen,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);
  localparam logic [3:0] INST_ID = 4'd0;
  localparam logic [3:0] DATA_ID = 4'd1;
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] ISSUE   = 1'b1;

  logic [0:0] state;
  logic       ar_hs;
  logic       inst_hit;
  logic       data_hit;
  logic       r_hs;
  logic       unused_r;

  // Single-beat INCR reads only.
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign arvalid      = (state == ISSUE);
  assign ar_hs        = arvalid && arready;
  assign inst_addr_ok = ar_hs && (arid == INST_ID);
  assign data_addr_ok = ar_hs && (arid == DATA_ID);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      arid   <= 4'd0;
      araddr <= 32'd0;
      arsize <= 3'd0;
    end else if (state == IDLE) begin
      // Data wins ties; it is held off by data_busy, so fetch still gets through.
      if (data_req && !data_busy) begin
        arid   <= DATA_ID;
        araddr <= data_addr;
        arsize <= data_size;
        state  <= ISSUE;
      end else if (inst_req && !inst_busy) begin
        arid   <= INST_ID;
        araddr <= inst_addr;
        arsize <= 3'd2;
        state  <= ISSUE;
      end
    end else if (arready) begin
      state <= IDLE;
    end
  end

  // Unknown RIDs are accepted and dropped so they cannot wedge the channel.
  assign inst_hit    = (rid == INST_ID);
  assign data_hit    = (rid == DATA_ID);
  assign rready      = inst_hit ? inst_rready : (data_hit ? data_rready : 1'b1);
  assign inst_rvalid = rvalid && inst_hit;
  assign data_rvalid = rvalid && data_hit;
  assign inst_rdata  = rdata;
  assign data_rdata  = rdata;
  assign r_hs        = rvalid && rready;

  // A set in the same cycle as a clear keeps the flag high.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_busy <= 1'b0;
      data_busy <= 1'b0;
    end else begin
      if (inst_addr_ok)          inst_busy <= 1'b1;
      else if (r_hs && inst_hit) inst_busy <= 1'b0;
      if (data_addr_ok)          data_busy <= 1'b1;
      else if (r_hs && data_hit) data_busy <= 1'b0;
    end
  end

  assign unused_r = ^{rresp, rlast};

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: directed scenarios, then randomized traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_axi_read_arbiter;
  localparam logic [3:0] INST_ID = 4'd0;
  localparam logic [3:0] DATA_ID = 4'd1;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_addr_ok, inst_rvalid, inst_rready;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_addr_ok, data_rvalid, data_rready;
  logic [31:0] data_addr, data_rdata;
  logic [2:0]  data_size;
  logic        inst_busy, data_busy;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi_read_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata), .inst_rready(inst_rready),
    .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
    .data_addr_ok(data_addr_ok), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .data_rready(data_rready), .inst_busy(inst_busy), .data_busy(data_busy),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arlen(arlen), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
  } ar_t;

  ar_t        ar_q[$];    // read granted but not yet accepted on AR
  bit [1:0]   busy_m;     // reads outstanding, indexed by id
  logic [3:0] slv_q[$];   // ids the memory model still owes a beat for
  bit         last_iok, last_dok, last_rhs;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check all outputs for the current cycle, then advance the model and clock.
  task automatic tick();
    ar_t      p;
    bit       e_arvalid, e_iok, e_dok, e_rready, hs, rhs;
    bit [1:0] old_busy;
    #1;
    e_arvalid = (ar_q.size() != 0);
    p = '{id: 4'd0, addr: 32'd0, size: 3'd0};
    if (e_arvalid) p = ar_q[0];
    e_iok    = e_arvalid && arready && (p.id == INST_ID);
    e_dok    = e_arvalid && arready && (p.id == DATA_ID);
    e_rready = (rid == INST_ID) ? inst_rready : (rid == DATA_ID) ? data_rready : 1'b1;
    chk("arvalid", arvalid, e_arvalid);
    chk("inst_addr_ok", inst_addr_ok, e_iok);
    chk("data_addr_ok", data_addr_ok, e_dok);
    chk("inst_busy", inst_busy, busy_m[0]);
    chk("data_busy", data_busy, busy_m[1]);
    chk("inst_rvalid", inst_rvalid, rvalid && (rid == INST_ID));
    chk("data_rvalid", data_rvalid, rvalid && (rid == DATA_ID));
    chk("rready", rready, e_rready);
    chk("inst_rdata", inst_rdata, rdata);
    chk("data_rdata", data_rdata, rdata);
    chk("ar_fixed", {arlen, arburst, arlock, arcache, arprot}, {8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
    if (e_arvalid) begin
      chk("arid", arid, p.id);
      chk("araddr", araddr, p.addr);
      chk("arsize", arsize, p.size);
    end
    hs  = e_arvalid && arready;
    rhs = rvalid && e_rready;
    last_iok = e_iok;
    last_dok = e_dok;
    last_rhs = rhs;
    if (hs) slv_q.push_back(p.id);
    if (rhs && rid < 4'd2)
      for (int i = 0; i < slv_q.size(); i++)
        if (slv_q[i] == rid) begin slv_q.delete(i); break; end
    if (rst) begin
      ar_q.delete();
      busy_m = 2'b00;
    end else begin
      old_busy = busy_m;
      if (rhs && rid < 4'd2) busy_m[rid[0]] = 1'b0;
      if (hs) begin
        busy_m[p.id[0]] = 1'b1;
        void'(ar_q.pop_front());
      end
      if (!e_arvalid) begin
        if (data_req && !old_busy[1])
          ar_q.push_back('{id: DATA_ID, addr: data_addr, size: data_size});
        else if (inst_req && !old_busy[0])
          ar_q.push_back('{id: INST_ID, addr: inst_addr, size: 3'd2});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a1;
    rst = 1'b1; inst_req = 0; inst_addr = 0; inst_rready = 0;
    data_req = 0; data_addr = 0; data_size = 0; data_rready = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    @(posedge clk); #1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_arid", arid, 4'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arsize", arsize, 3'd0);
    tick();

    // Lone instruction read.
    inst_req = 1; inst_addr = 32'hbfc0_0000; arready = 1; inst_rready = 1; data_rready = 1;
    tick();
    #1;
    chk("lone_arvalid", arvalid, 1'b1);
    chk("lone_arid", arid, INST_ID);
    chk("lone_arsize", arsize, 3'd2);
    chk("lone_addr_ok", inst_addr_ok, 1'b1);
    tick();
    inst_req = 0;
    rvalid = 1; rid = INST_ID; rdata = 32'h3c1d_0000;
    #1;
    chk("lone_busy", inst_busy, 1'b1);
    chk("lone_rvalid", inst_rvalid, 1'b1);
    chk("lone_rdata", inst_rdata, 32'h3c1d_0000);
    tick();
    rvalid = 0;
    #1;
    chk("lone_busy_clr", inst_busy, 1'b0);
    tick();

    // Contention: data first, fetch two cycles after its handshake.
    inst_req = 1; inst_addr = 32'h0040_0010;
    data_req = 1; data_addr = 32'h8000_1000; data_size = 3'd0;
    tick();
    #1;
    chk("cont_arid_d", arid, DATA_ID);
    chk("cont_arsize_d", arsize, 3'd0);
    chk("cont_araddr_d", araddr, 32'h8000_1000);
    tick();
    data_req = 0;
    #1;
    chk("cont_gap", arvalid, 1'b0);
    tick();
    #1;
    chk("cont_arid_i", arid, INST_ID);
    chk("cont_iok", inst_addr_ok, 1'b1);
    tick();
    inst_req = 0;

    // Out-of-order return.
    rvalid = 1; rid = DATA_ID; rdata = $urandom;
    #1;
    chk("ooo_both_busy", {inst_busy, data_busy}, 2'b11);
    chk("ooo_d_only", {inst_rvalid, data_rvalid}, 2'b01);
    tick();
    rid = INST_ID; rdata = $urandom;
    #1;
    chk("ooo_busy_mid", {inst_busy, data_busy}, 2'b10);
    chk("ooo_i_only", {inst_rvalid, data_rvalid}, 2'b10);
    tick();
    rvalid = 0;
    #1;
    chk("ooo_busy_end", {inst_busy, data_busy}, 2'b00);
    tick();

    // AR backpressure with a wandering data_addr.
    arready = 0; data_req = 1; a1 = 32'h8000_2004; data_addr = a1; data_size = 3'd2;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_arvalid", arvalid, 1'b1);
      chk("bp_araddr", araddr, a1);
      chk("bp_arid", arid, DATA_ID);
      chk("bp_no_ok", data_addr_ok, 1'b0);
      data_addr = $urandom;
      tick();
    end
    arready = 1;
    #1;
    chk("bp_ok", data_addr_ok, 1'b1);
    chk("bp_araddr_end", araddr, a1);
    tick();
    data_req = 0;
    rvalid = 1; rid = DATA_ID; rdata = $urandom;
    tick();
    rvalid = 0;

    // R stall on the instruction port.
    inst_req = 1; inst_addr = 32'h0040_0020;
    tick(); tick();
    inst_req = 0; inst_rready = 0; rvalid = 1; rid = INST_ID; rdata = $urandom;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rstall_rready", rready, 1'b0);
      chk("rstall_busy", inst_busy, 1'b1);
      tick();
    end
    inst_rready = 1;
    #1;
    chk("rstall_go", rready, 1'b1);
    tick();
    rvalid = 0;
    #1;
    chk("rstall_clr", inst_busy, 1'b0);
    tick();

    // Reset while an AR is pending and another read is outstanding.
    data_req = 1; data_addr = 32'h8000_3000; data_size = 3'd1;
    tick(); tick();
    data_req = 0; arready = 0; inst_req = 1; inst_addr = 32'h0040_0030;
    tick();
    #1;
    chk("mid_arvalid", arvalid, 1'b1);
    chk("mid_dbusy", data_busy, 1'b1);
    rst = 1;
    tick();
    rst = 0; inst_req = 0;
    #1;
    chk("rst_mid_arvalid", arvalid, 1'b0);
    chk("rst_mid_busy", {inst_busy, data_busy}, 2'b00);
    inst_rready = 0; data_rready = 0; rvalid = 1; rid = 4'd2; rdata = $urandom;
    #1;
    chk("stray_rready", rready, 1'b1);
    chk("stray_rvalid", {inst_rvalid, data_rvalid}, 2'b00);
    tick();
    rvalid = 0;
    slv_q.delete();
    tick();

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst     = ($urandom_range(0, 299) == 0);
      arready = ($urandom_range(0, 3) != 0);
      if (last_iok) inst_req = 0;
      else if (!inst_req && $urandom_range(0, 3) == 0) begin
        inst_req = 1; inst_addr = {$urandom} & 32'hffff_fffc;
      end
      if (last_dok) data_req = 0;
      else if (!data_req && $urandom_range(0, 3) == 0) begin
        data_req = 1; data_addr = $urandom; data_size = 3'($urandom_range(0, 2));
      end
      if (!rvalid || last_rhs) begin
        rvalid = 0;
        if (slv_q.size() != 0 && $urandom_range(0, 1) == 0) begin
          rvalid = 1; rid = slv_q[$urandom_range(0, slv_q.size() - 1)]; rdata = $urandom;
        end else if ($urandom_range(0, 29) == 0) begin
          rvalid = 1; rid = 4'($urandom_range(2, 15)); rdata = $urandom;
        end
      end
      inst_rready = ($urandom_range(0, 2) != 0);
      data_rready = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Shares the CPU's single AXI read channel (AR/R) between the instruction-fetch requester and the data-read (memory-stage) requester. It arbitrates and issues AR transactions with a per-requester ARID and routes R beats back by RID. It sits between the fetch/memory stages and the AXI bridge. It allows at most one outstanding read per requester, so at most two in flight in total.

## Interface
- INST_ID, 4'd0, ARID/RID tag for instruction reads
- DATA_ID, 4'd1, ARID/RID tag for data reads
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- inst_req  in  1  fetch requests a read
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  instruction AR accepted this cycle
- inst_rvalid  out  1  instruction data valid
- inst_rdata  out  32  instruction word
- inst_rready  in  1  fetch accepts instruction data
- data_req  in  1  memory stage requests a read
- data_addr  in  32  data address
- data_size  in  3  AXI size code for the data read
- data_addr_ok  out  1  data AR accepted this cycle
- data_rvalid  out  1  load data valid
- data_rdata  out  32  load data
- data_rready  in  1  memory stage accepts load data
- inst_busy, data_busy  out  1 each  read outstanding for that requester
- arid  out  4  tag of the AR in flight
- araddr  out  32  read address
- arsize  out  3  read size
- arlen  out  8  fixed 0
- arburst  out  2  fixed 2'b01
- arlock  out  2  fixed 0
- arcache  out  4  fixed 0
- arprot  out  3  fixed 0
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  response tag
- rdata  in  32  response data
- rresp  in  2  response status; ignored
- rlast  in  1  last beat; always 1 since arlen=0; ignored
- rvalid  in  1  R valid
- rready  out  1  R ready

## Operation
- AR FSM states: IDLE, ISSUE.
- IDLE arbitration:
  - If data_req && !data_busy, latch {DATA_ID, data_addr, data_size}.
  - Else if inst_req && !inst_busy, latch {INST_ID, inst_addr, 3'd2}.
  - Either grant moves the FSM to ISSUE. With no eligible request, stay in IDLE.
- Data has fixed priority. The instruction requester cannot starve, because data is blocked while data_busy is set.
- ISSUE:
  - arvalid=1. arid, araddr and arsize come from the latched registers and hold stable until the handshake.
  - On arvalid&&arready: pulse the matching *_addr_ok (combinational, in the handshake cycle), set the matching busy flag, and return to IDLE.
- Requesters hold req/addr until their addr_ok. The arbiter issues only from its latched copy, so input changes after the latch have no effect on the current transaction.
- R routing (combinational):
  - inst_rvalid = rvalid && rid==INST_ID.
  - data_rvalid = rvalid && rid==DATA_ID.
  - inst_rdata = data_rdata = rdata.
  - rready = inst_rready when rid==INST_ID, data_rready when rid==DATA_ID, and 1 for any other rid (the beat is dropped).
- On rvalid&&rready with a matching rid, clear that requester's busy flag.
- Simultaneous set and clear of the same busy flag cannot occur legally. If it does, the set wins.
- Responses may return in either order. The two busy flags are independent.
- rst in any state, including mid-ISSUE: FSM returns to IDLE, arvalid drops, both busy flags clear, and any late R beats are routed normally but clear no flag.

## Timing
- Reset values:
  - arvalid=0; arid=0; araddr=0; arsize=0.
  - inst_busy=data_busy=0.
  - inst_addr_ok=data_addr_ok=0.
  - inst_rvalid=data_rvalid=0 when rvalid=0.
- Request seen in IDLE at cycle N: arvalid rises at N+1. The earliest addr_ok is N+1, when arready is already high.
- After the handshake at cycle M, the FSM is in IDLE at M+1 and the next arvalid rises at M+2 at the earliest.
- The busy flag is visible the cycle after the AR handshake and clears the cycle after the R handshake.
- R path has zero added latency. rdata passes straight through.

## Test plan
- Lone instruction read: inst_req=1, addr=0xbfc00000, arready=1.
  - Expect arvalid at N+1 with arid=0, arsize=2, inst_addr_ok the same cycle.
  - rid=0, rdata=0x3c1d0000 → inst_rvalid=1 carrying that word; inst_busy clears the next cycle.
- Contention: inst_req and data_req both rise at N with data_addr=0x80001000, data_size=0.
  - Data issues first (arid=1, arsize=0).
  - Instruction issues next (arid=0) at M+2.
- Out-of-order return: both reads outstanding; rid=1 returns before rid=0.
  - Each beat reaches only its own port.
  - Busy flags clear independently.
- Backpressure: arready=0 for 5 cycles.
  - arvalid, araddr and arid stay stable; no addr_ok.
  - data_addr changing during the stall does not alter araddr.
- R stall: rid=0 beat with inst_rready=0 → rready=0 and inst_busy stays 1 until inst_rready=1.
- Reset mid-ISSUE: rst during arvalid=1 → arvalid=0 and both busy flags 0 the next cycle; a stray rid=2 beat is accepted with rready=1 and dropped.
